// File: rtl/serial_tx_frame.sv
// serial_tx_frame: serial frame transmitter (start, LSB-first data, optional parity, stop)
module serial_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              C,
  input  logic              RE,
  input  logic [DATA_W-1:0] D,
  input  logic              LOAD,
  output logic              READY,
  output logic              TX,
  output logic              DONE
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic par, par_n, tx_n, ready_n, done_n, wrap;
  assign wrap = cnt == CW'(CLKS_PER_BIT - 1);
  // state and registered outputs; TX idles high, reset aborts any frame
  always_ff @(posedge C or negedge RE) begin
    if (!RE) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par     <= 1'b0;
      TX      <= 1'b1;
      READY   <= 1'b1;
      DONE    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      par     <= par_n;
      TX      <= tx_n;
      READY   <= ready_n;
      DONE    <= done_n;
    end
  end
  // next state; TX is loaded with the upcoming bit at the edge where the divider wraps
  always_comb begin
    state_n   = state;
    cnt_n     = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    par_n     = par;
    tx_n      = TX;
    ready_n   = READY;
    done_n    = 1'b0;
    case (state)
      IDLE: if (LOAD) begin
        state_n = START;
        sh_n    = D;
        par_n   = (^D) ^ (PARITY_ODD != 0);
        tx_n    = 1'b0;
        ready_n = 1'b0;
      end
      START: if (wrap) begin
        state_n   = DATA;
        bit_cnt_n = '0;
        tx_n      = sh[0];
        sh_n      = sh >> 1;
      end
      DATA: if (wrap) begin
        if (bit_cnt == BW'(DATA_W - 1)) begin
          state_n = (PARITY_EN != 0) ? PARITY : STOP;
          tx_n    = (PARITY_EN != 0) ? par : 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          tx_n      = sh[0];
          sh_n      = sh >> 1;
        end
      end
      PARITY: if (wrap) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (wrap) begin
        state_n = IDLE;
        tx_n    = 1'b1;
        ready_n = 1'b1;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_tx_frame.sv
// tb_serial_tx_frame: randomized scoreboard bench over three transmitter configurations
module tb_serial_tx_frame;
  typedef struct {
    logic [15:0] bits;
    int          cyc;
  } ent_t;
  logic clk;
  int tests = 0;
  int fails = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int cfg, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, nm, a, e, $time);
    end
  endtask
  // expected line levels of one frame, bit n = n-th bit on the wire
  function automatic logic [15:0] frame(input logic [7:0] v, input int pe, input int po);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = v[i];
      ones += int'(v[i]);
    end
    if (pe != 0) f[9] = ((ones % 2) != 0) ^ (po != 0);
    return f;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int CPB = g == 0 ? 4 : g == 1 ? 1 : 3;
    localparam int PE  = g == 1 ? 0 : 1;
    localparam int PO  = g == 0 ? 0 : 1;
    localparam int F   = 10 + PE;
    logic re, load, ready, tx, done, fin, act;
    logic [7:0] d;
    ent_t q[$];
    ent_t cur;
    int rem = 0;
    int cyc = 0;
    int j = 0;
    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
      .C(clk), .RE(re), .D(d), .LOAD(load), .READY(ready), .TX(tx), .DONE(done)
    );
    // reference: a load is taken only when the previous frame plus its DONE cycle has elapsed
    always @(posedge clk or negedge re) begin
      if (!re) begin
        rem = 0;
        q.delete();
      end else begin
        cyc++;
        if (rem == 0 && load) begin
          q.push_back('{frame(d, PE, PO), cyc});
          rem = F * CPB;
        end else if (rem > 0) rem--;
      end
    end
    // monitor: follows the line each cycle and checks it against the popped frame
    always @(negedge clk) begin
      if (!re) act = 1'b0;
      else begin
        if (!act && !ready) begin
          if (q.size() == 0) chk("spurious_frame", g, q.size(), 1);
          else begin
            cur = q.pop_front();
            chk("start_cycle", g, cyc, cur.cyc);
            act = 1'b1;
            j = 0;
          end
        end
        if (act) begin
          if (j < F * CPB) chk("frame_bit", g, int'({ready, done, tx}), int'({2'b00, cur.bits[j/CPB]}));
          else begin
            chk("done_cycle", g, int'({ready, done, tx}), 3'b111);
            act = 1'b0;
          end
          j++;
        end else if (ready) chk("idle", g, int'({ready, done, tx}), 3'b101);
      end
    end
    initial begin
      re = 1'b0; load = 1'b0; d = '0; fin = 1'b0; act = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_state", g, int'({ready, done, tx}), 3'b101);
      re = 1'b1;
      foreach (q[i]) q.delete(i);
      @(posedge clk); #1 load = 1'b1; d = 8'hA5;
      @(posedge clk); #1 load = 1'b0;
      repeat (50) @(posedge clk);
      #1 load = 1'b1; d = 8'h3C;
      @(posedge clk); #1 load = 1'b0;
      repeat (10) @(posedge clk);
      #1 load = 1'b1; d = 8'hFF;
      @(posedge clk); #1 load = 1'b0; d = 8'h00;
      repeat (50) @(posedge clk);
      #1 load = 1'b1; d = 8'h01;
      @(posedge clk); #1 load = 1'b0;
      repeat (50) @(posedge clk);
      for (int i = 0; i < 400; i++) begin
        #1 load = ($urandom_range(3) == 0); d = 8'($urandom());
        @(posedge clk);
      end
      #1 load = 1'b1; d = 8'h96;
      @(posedge clk); #1 load = 1'b0;
      repeat (19) @(posedge clk);
      #3 re = 1'b0;
      #1 chk("async_reset", g, int'({ready, done, tx}), 3'b101);
      repeat (2) @(posedge clk);
      #1 re = 1'b1;
      @(posedge clk); #1 load = 1'b1; d = 8'hC3;
      @(posedge clk); #1 load = 1'b0;
      repeat (50) @(posedge clk);
      #1 load = 1'b1; d = 8'h55;
      repeat (150) @(posedge clk);
      #1 load = 1'b0;
      for (int i = 0; i < 300 && (q.size() != 0 || act); i++) @(posedge clk);
      chk("drain", g, q.size() + int'(act), 0);
      fin = 1'b1;
    end
  end
  initial begin
    for (int i = 0; i < 60000 && !(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin); i++) @(posedge clk);
    chk("finish", 0, int'({g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin}), 3'b111);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
Serial frame transmitter. It takes a DATA_W-bit parallel word on a load strobe and shifts it out on one line as: start bit, data bits LSB-first, optional parity bit, stop bit. It is the sending end of the team's serial-link exercise; a serial-in/parallel-out frame receiver sits at the far end. All state uses the team's edge-triggered D flip-flop cells with asynchronous reset.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, C cycles each serial bit is held (>=1)
PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)

Ports:
C  input  1  clock; all state updates on rising edge
RE  input  1  reset; asynchronous, active-low (RE=0 resets)
D  input  DATA_W  parallel word to transmit
LOAD  input  1  request to send D; sampled on a rising edge of C
READY  output  1  1 = idle, LOAD will be accepted
TX  output  1  serial line; idles high
DONE  output  1  one-cycle pulse after a frame completes

Behaviour:
- Reset (RE=0, asynchronous, any time, including mid-frame): TX=1, READY=1, DONE=0, state=IDLE, bit and clock counters=0, shift register cleared. No partial frame resumes after RE returns to 1.
- Frame length F = 2 + DATA_W + PARITY_EN bits. Frame duration = F*CLKS_PER_BIT cycles.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE: TX=1, READY=1. If LOAD=1 on edge k:
  - D is captured into the shift register.
  - Parity is computed from the captured D.
  - Next state is START, READY=0 and TX=0, all registered at edge k.
- Bit n of the frame (n=0 is the start bit) drives TX from edge k+n*CLKS_PER_BIT until edge k+(n+1)*CLKS_PER_BIT.
  - A clock-divider counter runs 0..CLKS_PER_BIT-1; the bit advances when it wraps.
  - CLKS_PER_BIT=1 means one bit per cycle, with no divider stall.
- DATA: bit i (i=0..DATA_W-1) is D[i] as captured, i.e. LSB first. A bit counter runs 0..DATA_W-1 and exits to PARITY/STOP after the last bit.
- PARITY: even parity is the XOR of the captured bits; odd parity is its inverse.
- STOP: TX=1 for CLKS_PER_BIT cycles. At edge k+F*CLKS_PER_BIT the block enters IDLE, READY=1, and DONE=1 for exactly that one cycle.
- Back-to-back frames: LOAD is first accepted at edge k+F*CLKS_PER_BIT+1. TX stays 1 through the DONE cycle, so the idle gap is one cycle.
- LOAD=1 while READY=0 is ignored, with no queuing. Changes on D while READY=0 have no effect.
- TX, READY and DONE are registered outputs and glitch-free.
- LOAD held high continuously means frames are sent back-to-back with the one-cycle gap.

Test Plan:
- Defaults, D=8'hA5, LOAD pulse at edge k. TX must be:
  - 0 for cycles k..k+3
  - then 1,0,1,0,0,1,0,1 (4 cycles each)
  - then parity 0, then stop 1
  - DONE=1 only in cycle k+44; READY=0 over k..k+43.
- PARITY_ODD=1, D=8'h01 -> parity bit 0. With PARITY_ODD=0, same D -> parity bit 1.
- CLKS_PER_BIT=1, PARITY_EN=0, D=8'hFF, LOAD at k -> TX=0 at k, 1 for k+1..k+9, DONE at k+10.
- D=8'h3C loaded, then LOAD=1 with D=8'hFF at k+12 -> transmitted data stays 0,0,1,1,1,1,0,0 and no second frame starts.
- Drop RE to 0 mid-DATA at k+20 (asynchronously, between edges) -> TX=1, READY=1, DONE=0 immediately. After RE=1, a new LOAD sends a complete, correct frame.
- LOAD held 1 with D=8'h55 -> consecutive frames each 44 cycles, separated by exactly one DONE/idle cycle with TX=1.
